pipeline_wb_arb: RTL and testbench
==================================

// Module: pipeline_wb_arb
// PURPOSE
//   Parametrised write-back stage with two producers sharing the single RF write port.
//   - In-order path from MEM: one-hot source select over NSRC result slots, with load-data alignment.
//   - Late-result path from a long-latency unit (mul/div): buffered in a small FIFO.
//   Registers the winning write (rd, data, enable) and drives the RF write port in ID.
// PARAMETERS
//   XLEN        32  data width
//   NSRC        4   number of result slots / one-hot select width
//   LOAD_SLOT   2   slot index holding raw D-memory read data (aligned before select)
//   LQ_DEPTH    2   late-result FIFO depth (>=1)
//   STARVE_MAX  4   cycles a non-empty FIFO may wait before the main path is stalled (>=1)
// PORTS
//   clk                  in   1               rising-edge clock
//   reset                in   1               synchronous, active-high
//   valid_m_i            in   1               MEM-stage slot holds a valid instruction
//   reg_write_en_m_i     in   1               instruction writes the RF
//   rd_idx_m_i           in   5               destination register
//   result_src_m_i       in   NSRC            one-hot slot select
//   src_data_m_i         in   NSRC*XLEN       slot k = [k*XLEN +: XLEN]
//   load_funct3_m_i      in   3               RV32 load funct3
//   load_offset_m_i      in   2               address[1:0] of the load
//   stall_m_o            out  1               MEM inputs not consumed this cycle; hold them
//   lq_valid_i           in   1               late unit presents a result
//   lq_rd_idx_i          in   5               late-result destination
//   lq_data_i            in   XLEN            late-result data
//   lq_ready_o           out  1               FIFO accepts the late result this cycle
//   lq_count_o           out  $clog2(LQ_DEPTH+1)  FIFO occupancy
//   reg_write_en_w_o     out  1               RF write enable (registered)
//   rd_idx_w_o           out  5               RF write index (registered)
//   write_back_data_w_o  out  XLEN            RF write data (registered)
// BEHAVIOUR
//   - Reset (sync, active-high, one edge): all registered outputs 0, FIFO emptied, starve counter 0.
//     While reset is high, lq_ready_o=0 and stall_m_o=0.
//     Mid-operation reset discards all queued late results.
//   - Main consume: valid_m_i & !stall_m_o. Main write: consume & reg_write_en_m_i & rd_idx_m_i!=0.
//   - Select: AND-OR of slots by result_src_m_i.
//     All-zero select -> data 0; multi-hot -> bitwise OR of the selected slots (legacy-compatible).
//   - Alignment (LOAD_SLOT only, applied before select):
//     - 000 LB: sign-extend byte [off*8 +: 8]
//     - 100 LBU: zero-extend byte [off*8 +: 8]
//     - 001 LH: sign-extend half [off[1]*16 +: 16]
//     - 101 LHU: zero-extend half [off[1]*16 +: 16]
//     - 010 and others: word unchanged
//     - Half loads ignore off[0].
//   - FIFO:
//     - Push on lq_valid_i & lq_ready_o; lq_ready_o = !reset & (count < LQ_DEPTH).
//       No pass-through when full.
//     - Pop the head when the port is free, i.e. no main write this cycle.
//       Pushed entry is poppable from the next cycle, so late latency is >=2 cycles.
//     - Push and pop in the same cycle: count unchanged. FIFO order preserved; pointers wrap mod LQ_DEPTH.
//   - Output register (next edge), one winner per cycle:
//     - main write -> {1, rd_idx_m_i, selected data}
//     - else pop -> {1, head rd, head data}; head rd==0 -> enable 0, entry still popped
//     - else enable 0; rd and data hold their previous values
//     - Main-path latency is 1 cycle.
//   - Starvation:
//     - starve_cnt increments each cycle the FIFO is non-empty and not popped;
//       clears on pop or when empty; saturates.
//     - stall_m_o = (starve_cnt >= STARVE_MAX), combinational from the register.
//     - During stall the main path is not consumed and the head is force-popped,
//       so stall lasts exactly 1 cycle.
//   - Ordering hazards between queued late results and younger main writes to the same rd
//     are prevented by the ID-stage scoreboard; this block does not check them.
// TESTING
//   1) Reset held 2 cycles with lq_valid_i=1 -> reg_write_en_w_o=0, lq_ready_o=0, lq_count_o=0; no push.
//   2) ALU slot0=32'h1234_5678, src=0001, rd=5 -> next cycle en=1, rd=5, data=32'h1234_5678.
//      Same with rd=0 -> en=0.
//   3) Load word 32'h80FF_7F01:
//      - LB off=3 -> FFFF_FF80
//      - LBU off=2 -> 0000_00FF
//      - LH off=2 -> FFFF_80FF
//      - LHU off=1 -> 0000_7F01
//   4) Late push rd=7 data=9 while main idle -> written 2 cycles after push, count 1->0.
//      Push+pop in the same cycle keeps count.
//   5) Main writes every cycle, FIFO holds 1 entry -> stall_m_o=1 on wait cycle STARVE_MAX=4.
//      That cycle the entry is written and main is held; next cycle stall=0 and main resumes.
//   6) Fill FIFO to LQ_DEPTH -> lq_ready_o=0 and extra lq_valid_i ignored.
//      Reset mid-fill -> count 0 and no stale write after reset.

Source files
------------

// File: rtl/pipeline_wb_arb.sv
// Write-back arbiter: in-order MEM results and a FIFO of late (mul/div) results share
// the single register-file write port, with a starvation guard that briefly stalls MEM.
module pipeline_wb_arb #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned NSRC       = 4,
  parameter int unsigned LOAD_SLOT  = 2,
  parameter int unsigned LQ_DEPTH   = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        valid_m_i,
  input  logic                        reg_write_en_m_i,
  input  logic [4:0]                  rd_idx_m_i,
  input  logic [NSRC-1:0]             result_src_m_i,
  input  logic [NSRC*XLEN-1:0]        src_data_m_i,
  input  logic [2:0]                  load_funct3_m_i,
  input  logic [1:0]                  load_offset_m_i,
  output logic                        stall_m_o,
  input  logic                        lq_valid_i,
  input  logic [4:0]                  lq_rd_idx_i,
  input  logic [XLEN-1:0]             lq_data_i,
  output logic                        lq_ready_o,
  output logic [$clog2(LQ_DEPTH+1)-1:0] lq_count_o,
  output logic                        reg_write_en_w_o,
  output logic [4:0]                  rd_idx_w_o,
  output logic [XLEN-1:0]             write_back_data_w_o
);

  localparam int unsigned CntW = $clog2(LQ_DEPTH + 1);
  localparam int unsigned PtrW = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
  localparam int unsigned StW  = $clog2(STARVE_MAX + 1);

  logic [4:0]      lq_rd_q   [LQ_DEPTH];
  logic [XLEN-1:0] lq_data_q [LQ_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic [StW-1:0]  starve_q;

  logic            push, pop, main_wr;
  logic [XLEN-1:0] raw_load, aligned, sel_data;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(LQ_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign stall_m_o  = !reset && (starve_q >= StW'(STARVE_MAX));
  assign lq_ready_o = !reset && (count_q < CntW'(LQ_DEPTH));
  assign lq_count_o = count_q;

  assign main_wr = valid_m_i && !stall_m_o && reg_write_en_m_i && (rd_idx_m_i != 5'd0);
  assign push    = lq_valid_i && lq_ready_o;
  // Port is free whenever MEM does not write; during a stall this force-pops the head.
  assign pop     = (count_q != '0) && !main_wr;

  assign raw_load = src_data_m_i[LOAD_SLOT*XLEN +: XLEN];
  assign ld_byte  = raw_load[{load_offset_m_i, 3'b000} +: 8];
  assign ld_half  = raw_load[{load_offset_m_i[1], 4'b0000} +: 16];

  always_comb begin
    aligned = raw_load;
    case (load_funct3_m_i)
      3'b000:  aligned = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      3'b100:  aligned = {{(XLEN-8){1'b0}}, ld_byte};
      3'b001:  aligned = {{(XLEN-16){ld_half[15]}}, ld_half};
      3'b101:  aligned = {{(XLEN-16){1'b0}}, ld_half};
      default: aligned = raw_load;
    endcase
  end

  // AND-OR select; multi-hot ORs the slots together.
  always_comb begin
    sel_data = '0;
    for (int k = 0; k < NSRC; k++) begin
      if (result_src_m_i[k]) begin
        sel_data = sel_data | ((k == LOAD_SLOT) ? aligned : src_data_m_i[k*XLEN +: XLEN]);
      end
    end
  end

  // Storage is not reset; push is already gated off while reset is high.
  always_ff @(posedge clk) begin
    if (push) begin
      lq_rd_q[wr_ptr_q]   <= lq_rd_idx_i;
      lq_data_q[wr_ptr_q] <= lq_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q            <= '0;
      rd_ptr_q            <= '0;
      count_q             <= '0;
      starve_q            <= '0;
      reg_write_en_w_o    <= 1'b0;
      rd_idx_w_o          <= '0;
      write_back_data_w_o <= '0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);

      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase

      if ((count_q == '0) || pop) begin
        starve_q <= '0;
      end else if (starve_q < StW'(STARVE_MAX)) begin
        starve_q <= starve_q + 1'b1;
      end

      if (main_wr) begin
        reg_write_en_w_o    <= 1'b1;
        rd_idx_w_o          <= rd_idx_m_i;
        write_back_data_w_o <= sel_data;
      end else if (pop) begin
        reg_write_en_w_o    <= (lq_rd_q[rd_ptr_q] != 5'd0);
        rd_idx_w_o          <= lq_rd_q[rd_ptr_q];
        write_back_data_w_o <= lq_data_q[rd_ptr_q];
      end else begin
        reg_write_en_w_o    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_wb_arb.sv
// Directed bench for pipeline_wb_arb: reset, select/alignment, late FIFO, starvation, fill.
module tb_pipeline_wb_arb;

  logic         clk = 1'b0;
  logic         reset;
  logic         valid_m_i;
  logic         reg_write_en_m_i;
  logic [4:0]   rd_idx_m_i;
  logic [3:0]   result_src_m_i;
  logic [127:0] src_data_m_i;
  logic [2:0]   load_funct3_m_i;
  logic [1:0]   load_offset_m_i;
  logic         stall_m_o;
  logic         lq_valid_i;
  logic [4:0]   lq_rd_idx_i;
  logic [31:0]  lq_data_i;
  logic         lq_ready_o;
  logic [1:0]   lq_count_o;
  logic         reg_write_en_w_o;
  logic [4:0]   rd_idx_w_o;
  logic [31:0]  write_back_data_w_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipeline_wb_arb dut (
    .clk                 (clk),
    .reset               (reset),
    .valid_m_i           (valid_m_i),
    .reg_write_en_m_i    (reg_write_en_m_i),
    .rd_idx_m_i          (rd_idx_m_i),
    .result_src_m_i      (result_src_m_i),
    .src_data_m_i        (src_data_m_i),
    .load_funct3_m_i     (load_funct3_m_i),
    .load_offset_m_i     (load_offset_m_i),
    .stall_m_o           (stall_m_o),
    .lq_valid_i          (lq_valid_i),
    .lq_rd_idx_i         (lq_rd_idx_i),
    .lq_data_i           (lq_data_i),
    .lq_ready_o          (lq_ready_o),
    .lq_count_o          (lq_count_o),
    .reg_write_en_w_o    (reg_write_en_w_o),
    .rd_idx_w_o          (rd_idx_w_o),
    .write_back_data_w_o (write_back_data_w_o)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wb(input string tag, input logic en, input logic [4:0] rd, input logic [31:0] d);
    chk({tag, ".en"}, 32'(reg_write_en_w_o), 32'(en));
    chk({tag, ".rd"}, 32'(rd_idx_w_o), 32'(rd));
    chk({tag, ".data"}, write_back_data_w_o, d);
  endtask

  initial begin
    reset = 1'b1;
    valid_m_i = 1'b0;
    reg_write_en_m_i = 1'b0;
    rd_idx_m_i = '0;
    result_src_m_i = '0;
    src_data_m_i = '0;
    load_funct3_m_i = 3'b010;
    load_offset_m_i = '0;
    lq_valid_i = 1'b1;
    lq_rd_idx_i = 5'd3;
    lq_data_i = 32'hDEAD_BEEF;

    // 1) reset held two cycles with a late result offered
    #1;
    chk("rst.ready", 32'(lq_ready_o), 32'd0);
    chk("rst.stall", 32'(stall_m_o), 32'd0);
    step();
    step();
    chk("rst.en", 32'(reg_write_en_w_o), 32'd0);
    chk("rst.count", 32'(lq_count_o), 32'd0);
    chk("rst.ready2", 32'(lq_ready_o), 32'd0);
    reset = 1'b0;
    lq_valid_i = 1'b0;
    #1;
    chk("post_rst.ready", 32'(lq_ready_o), 32'd1);

    // 2) ALU slot 0
    valid_m_i = 1'b1;
    reg_write_en_m_i = 1'b1;
    rd_idx_m_i = 5'd5;
    result_src_m_i = 4'b0001;
    src_data_m_i[31:0] = 32'h1234_5678;
    src_data_m_i[63:32] = 32'h0000_0F00;
    src_data_m_i[95:64] = 32'h80FF_7F01;
    step();
    wb("alu", 1'b1, 5'd5, 32'h1234_5678);
    rd_idx_m_i = 5'd0;
    step();
    wb("alu_rd0", 1'b0, 5'd5, 32'h1234_5678);

    // 3) load alignment from slot 2
    rd_idx_m_i = 5'd10;
    result_src_m_i = 4'b0100;
    load_funct3_m_i = 3'b000; load_offset_m_i = 2'd3;
    step();
    wb("lb3", 1'b1, 5'd10, 32'hFFFF_FF80);
    load_funct3_m_i = 3'b100; load_offset_m_i = 2'd2;
    step();
    chk("lbu2", write_back_data_w_o, 32'h0000_00FF);
    load_funct3_m_i = 3'b001; load_offset_m_i = 2'd2;
    step();
    chk("lh2", write_back_data_w_o, 32'hFFFF_80FF);
    load_funct3_m_i = 3'b101; load_offset_m_i = 2'd1;
    step();
    chk("lhu1", write_back_data_w_o, 32'h0000_7F01);
    load_funct3_m_i = 3'b010; load_offset_m_i = 2'd3;
    step();
    chk("lw", write_back_data_w_o, 32'h80FF_7F01);
    result_src_m_i = 4'b0000;
    step();
    wb("sel_none", 1'b1, 5'd10, 32'h0);
    result_src_m_i = 4'b0011;
    step();
    chk("sel_multi", write_back_data_w_o, 32'h1234_5F78);

    // 4) late result with main idle, then push+pop in one cycle
    valid_m_i = 1'b0;
    lq_valid_i = 1'b1; lq_rd_idx_i = 5'd7; lq_data_i = 32'd9;
    step();
    lq_valid_i = 1'b0;
    chk("late.count1", 32'(lq_count_o), 32'd1);
    chk("late.en_wait", 32'(reg_write_en_w_o), 32'd0);
    step();
    chk("late.count0", 32'(lq_count_o), 32'd0);
    wb("late", 1'b1, 5'd7, 32'd9);
    lq_valid_i = 1'b1; lq_rd_idx_i = 5'd8; lq_data_i = 32'd11;
    step();
    chk("pp.count_a", 32'(lq_count_o), 32'd1);
    lq_rd_idx_i = 5'd9; lq_data_i = 32'd12;
    step();
    chk("pp.count_b", 32'(lq_count_o), 32'd1);
    wb("pp.first", 1'b1, 5'd8, 32'd11);
    lq_valid_i = 1'b0;
    step();
    chk("pp.count_c", 32'(lq_count_o), 32'd0);
    wb("pp.second", 1'b1, 5'd9, 32'd12);

    // 5) starvation: main writes every cycle while one late entry waits
    valid_m_i = 1'b1;
    rd_idx_m_i = 5'd1;
    result_src_m_i = 4'b0001;
    src_data_m_i[31:0] = 32'h0000_AAAA;
    lq_valid_i = 1'b1; lq_rd_idx_i = 5'd20; lq_data_i = 32'h55;
    step();
    lq_valid_i = 1'b0;
    chk("starve.count", 32'(lq_count_o), 32'd1);
    chk("starve.s0", 32'(stall_m_o), 32'd0);
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("starve.wait", 32'(stall_m_o), 32'd0);
      wb("starve.main", 1'b1, 5'd1, 32'h0000_AAAA);
    end
    step();
    chk("starve.stall", 32'(stall_m_o), 32'd1);
    rd_idx_m_i = 5'd2;
    src_data_m_i[31:0] = 32'h0000_BBBB;
    step();
    chk("starve.unstall", 32'(stall_m_o), 32'd0);
    chk("starve.count0", 32'(lq_count_o), 32'd0);
    wb("starve.pop", 1'b1, 5'd20, 32'h55);
    step();
    wb("starve.resume", 1'b1, 5'd2, 32'h0000_BBBB);

    // 6) fill the FIFO under main traffic, then reset mid-fill
    rd_idx_m_i = 5'd3;
    lq_valid_i = 1'b1; lq_rd_idx_i = 5'd21; lq_data_i = 32'd1;
    step();
    lq_rd_idx_i = 5'd22; lq_data_i = 32'd2;
    chk("fill.ready1", 32'(lq_ready_o), 32'd1);
    step();
    chk("fill.count2", 32'(lq_count_o), 32'd2);
    chk("fill.ready0", 32'(lq_ready_o), 32'd0);
    lq_rd_idx_i = 5'd23; lq_data_i = 32'd3;
    step();
    chk("fill.ignored", 32'(lq_count_o), 32'd2);
    reset = 1'b1;
    #1;
    chk("mid_rst.ready", 32'(lq_ready_o), 32'd0);
    chk("mid_rst.stall", 32'(stall_m_o), 32'd0);
    step();
    chk("mid_rst.count", 32'(lq_count_o), 32'd0);
    wb("mid_rst.out", 1'b0, 5'd0, 32'd0);
    reset = 1'b0;
    valid_m_i = 1'b0;
    lq_valid_i = 1'b0;
    step();
    chk("no_stale.en1", 32'(reg_write_en_w_o), 32'd0);
    step();
    chk("no_stale.en2", 32'(reg_write_en_w_o), 32'd0);
    chk("no_stale.count", 32'(lq_count_o), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
